// File: rtl/apb_pkg.sv
// apb_pkg: shared APB state encoding and bus widths
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;

endpackage

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB3 requester with wait-state timeout
module apb_master
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [APB_ADDR_W-1:0] cmd_addr,
    input  logic [APB_DATA_W-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [APB_ADDR_W-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [APB_DATA_W-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [APB_DATA_W-1:0] PRDATA,
    input  logic                  PSLVERR
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    apb_state_t state, state_nx;
    logic [7:0] wait_cnt;
    logic       timeout_hit;

    // the current stalled cycle would be the TIMEOUT_CYCLES-th one
    assign timeout_hit = (wait_cnt + 8'd1) == TO_LIMIT;

    // state register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nx;
    end

    // next state and bus/handshake decode, all from registered state
    always_comb begin
        state_nx  = state;
        cmd_ready = state == IDLE;
        PSEL      = state == SETUP || state == ACCESS;
        PENABLE   = state == ACCESS;
        rsp_valid = state == RESP;
        case (state)
            IDLE:    state_nx = cmd_valid ? SETUP : IDLE;
            SETUP:   state_nx = ACCESS;
            ACCESS:  state_nx = (PREADY || timeout_hit) ? RESP : ACCESS;
            default: state_nx = IDLE;
        endcase
    end

    // latch the accepted command; held through the transfer and afterwards
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
        end else if (state == IDLE && cmd_valid) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_wdata;
        end
    end

    // count stalled ACCESS cycles, restarting for each transfer
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                        wait_cnt <= '0;
        else if (state == SETUP)             wait_cnt <= '0;
        else if (state == ACCESS && !PREADY) wait_cnt <= wait_cnt + 8'd1;
    end

    // capture completion status; PREADY takes priority over a coincident timeout
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (state == ACCESS && PREADY) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
        end else if (state == ACCESS && timeout_hit) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed checks against a FIR-slave model and a scripted responder
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    logic        use_fir = 1'b1;
    logic [31:0] p_data_back = 32'h0000_BEEF;
    logic        fir_ready;
    logic [1:0]  fir_cnt;
    int          fir_wr_cnt = 0;
    logic [31:0] fir_wr_data = '0;
    logic [31:0] fir_wr_addr = '0;

    int          beh_wait = 0;
    logic        beh_err = 1'b0;
    logic [31:0] beh_rdata = '0;
    int          acc_n;
    int          rsp_cnt = 0;

    int n_chk = 0;
    int n_pass = 0;

    apb_master #(.TIMEOUT_CYCLES(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    assign PREADY  = use_fir ? fir_ready : (acc_n == beh_wait);
    assign PRDATA  = use_fir ? p_data_back : beh_rdata;
    assign PSLVERR = use_fir ? 1'b0 : beh_err;

    // FIR slave: registered PREADY, one wait for writes, two for reads
    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            fir_ready <= 1'b0;
            fir_cnt   <= '0;
        end else if (!PSEL || !PENABLE || fir_ready) begin
            fir_ready <= 1'b0;
            fir_cnt   <= '0;
        end else begin
            fir_cnt   <= fir_cnt + 2'd1;
            fir_ready <= fir_cnt == (PWRITE ? 2'd0 : 2'd1);
        end
    end

    // FIR slave p_wr strobe capture
    always @(posedge PCLK) begin
        if (use_fir && PSEL && PENABLE && PWRITE && fir_ready) begin
            fir_wr_cnt  <= fir_wr_cnt + 1;
            fir_wr_data <= PWDATA;
            fir_wr_addr <= PADDR;
        end
    end

    // scripted responder: counts ACCESS cycles of the current transfer
    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) acc_n <= 0;
        else          acc_n <= (PSEL && PENABLE) ? acc_n + 1 : 0;
    end

    // response pulse counter
    always @(posedge PCLK) begin
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output int rc, output logic [15:0] ps, output logic [15:0] pe,
                           output logic [31:0] rd, output logic er, output logic tm);
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        rc = -1; ps = '0; pe = '0; rd = 'x; er = 1'bx; tm = 1'bx;
        for (int c = 1; c < 16 && rc < 0; c++) begin
            ps[c] = PSEL;
            pe[c] = PENABLE;
            if (rsp_valid) begin
                rc = c; rd = rsp_rdata; er = rsp_err; tm = rsp_timeout;
            end
            @(posedge PCLK); #1;
        end
    endtask

    task automatic test_reset;
        #12;
        n_chk++;
        if ({cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout} !== 7'b1000000)
            $display("FAIL reset_ctrl got %b want 1000000",
                     {cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout});
        else n_pass++;
        n_chk++;
        if ({PADDR, PWDATA, rsp_rdata} !== 96'h0)
            $display("FAIL reset_data got %h/%h/%h want 0", PADDR, PWDATA, rsp_rdata);
        else n_pass++;
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        n_chk++;
        if ({cmd_ready, PSEL} !== 2'b10) $display("FAIL reset_idle got %b want 10", {cmd_ready, PSEL});
        else n_pass++;
    endtask

    task automatic test_fir_write;
        int rc; logic [15:0] ps, pe; logic [31:0] rd; logic er, tm; int w0;
        use_fir = 1'b1;
        w0 = fir_wr_cnt;
        run_cmd(1'b1, 32'h5, 32'h0000_1234, rc, ps, pe, rd, er, tm);
        n_chk++;
        if (rc !== 4) $display("FAIL wr_rsp_cycle got %0d want 4", rc); else n_pass++;
        n_chk++;
        if ({ps, pe} !== {16'h000E, 16'h000C})
            $display("FAIL wr_phases got psel=%h pen=%h want 000e/000c", ps, pe);
        else n_pass++;
        n_chk++;
        if ({er, rd} !== 33'h0) $display("FAIL wr_rsp got err=%b rdata=%h want 0/0", er, rd);
        else n_pass++;
        n_chk++;
        if (fir_wr_cnt - w0 !== 1 || fir_wr_data !== 32'h1234 || fir_wr_addr !== 32'h5)
            $display("FAIL wr_strobe got n=%0d data=%h addr=%h want 1/1234/5",
                     fir_wr_cnt - w0, fir_wr_data, fir_wr_addr);
        else n_pass++;
    endtask

    task automatic test_fir_read;
        int rc; logic [15:0] ps, pe; logic [31:0] rd; logic er, tm;
        use_fir = 1'b1;
        run_cmd(1'b0, 32'h5, 32'h0, rc, ps, pe, rd, er, tm);
        n_chk++;
        if (rc !== 5) $display("FAIL rd_rsp_cycle got %0d want 5", rc); else n_pass++;
        n_chk++;
        if ({ps, pe} !== {16'h001E, 16'h001C})
            $display("FAIL rd_phases got psel=%h pen=%h want 001e/001c", ps, pe);
        else n_pass++;
        n_chk++;
        if ({er, rd} !== {1'b0, 32'h0000_BEEF})
            $display("FAIL rd_rsp got err=%b rdata=%h want 0/0000beef", er, rd);
        else n_pass++;
    endtask

    task automatic test_slverr;
        int rc; logic [15:0] ps, pe; logic [31:0] rd; logic er, tm;
        use_fir = 1'b0; beh_wait = 0; beh_err = 1'b1; beh_rdata = 32'hDEAD_0001;
        run_cmd(1'b0, 32'h40, 32'h0, rc, ps, pe, rd, er, tm);
        n_chk++;
        if (rc !== 3 || ps !== 16'h0006) $display("FAIL err_cycle got rc=%0d psel=%h want 3/0006", rc, ps);
        else n_pass++;
        n_chk++;
        if ({er, tm, rd} !== {2'b10, 32'hDEAD_0001})
            $display("FAIL err_rsp got err=%b to=%b rdata=%h want 1/0/dead0001", er, tm, rd);
        else n_pass++;
        @(posedge PCLK); #1;
        n_chk++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 32'hDEAD_0001})
            $display("FAIL rsp_hold got v=%b err=%b rdata=%h want 0/1/dead0001",
                     rsp_valid, rsp_err, rsp_rdata);
        else n_pass++;
    endtask

    task automatic test_timeout;
        int rc; logic [15:0] ps, pe; logic [31:0] rd; logic er, tm;
        use_fir = 1'b0; beh_wait = 255; beh_err = 1'b0; beh_rdata = 32'h1234_5678;
        run_cmd(1'b0, 32'h44, 32'h0, rc, ps, pe, rd, er, tm);
        n_chk++;
        if (rc !== 6 || ps !== 16'h003E || pe !== 16'h003C)
            $display("FAIL to_cycles got rc=%0d psel=%h pen=%h want 6/003e/003c", rc, ps, pe);
        else n_pass++;
        n_chk++;
        if ({er, tm, rd} !== {2'b11, 32'h0})
            $display("FAIL to_rsp got err=%b to=%b rdata=%h want 1/1/0", er, tm, rd);
        else n_pass++;
        beh_wait = 3;
        run_cmd(1'b0, 32'h48, 32'h0, rc, ps, pe, rd, er, tm);
        n_chk++;
        if (rc !== 6 || {er, tm, rd} !== {2'b00, 32'h1234_5678})
            $display("FAIL to_edge got rc=%0d err=%b to=%b rdata=%h want 6/0/0/12345678",
                     rc, er, tm, rd);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [3] = '{32'h10, 32'h14, 32'h18};
        logic [31:0] datas [3] = '{32'hA1, 32'hB2, 32'hC3};
        int acc [3] = '{-1, -1, -1};
        int k = 0;
        int paddr_bad = 0;
        int w0;
        logic [19:0] rdy = '0;
        use_fir = 1'b1;
        w0 = fir_wr_cnt;
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addrs[0]; cmd_wdata = datas[0];
        for (int c = 0; c < 20; c++) begin
            rdy[c] = cmd_ready;
            if (PSEL && k > 0 && PADDR !== addrs[k-1]) paddr_bad++;
            if (cmd_ready && cmd_valid) begin
                acc[k] = c;
                k++;
            end
            @(posedge PCLK); #1;
            if (k == 3) cmd_valid = 1'b0;
            else begin
                cmd_addr = addrs[k]; cmd_wdata = datas[k];
            end
            @(negedge PCLK);
        end
        n_chk++;
        if (acc[0] !== 0 || acc[1] !== 5 || acc[2] !== 10)
            $display("FAIL b2b_accepts got %0d,%0d,%0d want 0,5,10", acc[0], acc[1], acc[2]);
        else n_pass++;
        n_chk++;
        if (rdy !== 20'hF8421) $display("FAIL b2b_ready got %h want f8421", rdy); else n_pass++;
        n_chk++;
        if (paddr_bad !== 0) $display("FAIL b2b_paddr got %0d unstable cycles want 0", paddr_bad);
        else n_pass++;
        n_chk++;
        if (fir_wr_cnt - w0 !== 3 || fir_wr_data !== 32'hC3 || fir_wr_addr !== 32'h18)
            $display("FAIL b2b_writes got n=%0d data=%h addr=%h want 3/c3/18",
                     fir_wr_cnt - w0, fir_wr_data, fir_wr_addr);
        else n_pass++;
    endtask

    task automatic test_async_reset;
        int rc; logic [15:0] ps, pe; logic [31:0] rd; logic er, tm; int r0;
        use_fir = 1'b1;
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        @(posedge PCLK); #1;
        n_chk++;
        if ({PSEL, PENABLE} !== 2'b11) $display("FAIL ar_access got %b want 11", {PSEL, PENABLE});
        else n_pass++;
        r0 = rsp_cnt;
        #2 PRESETn = 1'b0;
        #1;
        n_chk++;
        if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b0010 || PADDR !== 32'h0)
            $display("FAIL ar_drop got sel/en/rdy/v=%b paddr=%h want 0010/0",
                     {PSEL, PENABLE, cmd_ready, rsp_valid}, PADDR);
        else n_pass++;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        n_chk++;
        if (rsp_cnt !== r0 || cmd_ready !== 1'b1)
            $display("FAIL ar_norsp got pulses=%0d ready=%b want 0/1", rsp_cnt - r0, cmd_ready);
        else n_pass++;
        run_cmd(1'b0, 32'h5, 32'h0, rc, ps, pe, rd, er, tm);
        n_chk++;
        if (rc !== 5 || {er, rd} !== {1'b0, 32'h0000_BEEF})
            $display("FAIL ar_recover got rc=%0d err=%b rdata=%h want 5/0/0000beef", rc, er, rd);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_fir_write;
        test_fir_read;
        test_slverr;
        test_timeout;
        test_back_to_back;
        test_async_reset;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
